// File: rtl/salamander_ioctl_loader.sv
// salamander_ioctl_loader
// Consumes the HPS ioctl download stream. ROM-index bytes are packed into
// big-endian 16-bit words and written to the 68000 ROM port. o_IOCTL_WAIT
// stalls the source while a word write is outstanding. DIP-index bytes are
// held in registers. o_ROM_DONE releases the game core once the ROM image
// has been fully written.
module salamander_ioctl_loader #(
    parameter logic [15:0] ROM_INDEX = 16'd0,
    parameter logic [15:0] DIP_INDEX = 16'd254,
    parameter int          MEM_AW    = 26
) (
    input  logic              i_HPSIO_CLK,
    input  logic              i_RST,
    input  logic              i_IOCTL_DOWNLOAD,
    input  logic [15:0]       i_IOCTL_INDEX,
    input  logic [26:0]       i_IOCTL_ADDR,
    input  logic [7:0]        i_IOCTL_DATA,
    input  logic              i_IOCTL_WR,
    output logic              o_IOCTL_WAIT,
    output logic              o_MEM_REQ,
    output logic [MEM_AW-1:0] o_MEM_ADDR,
    output logic [15:0]       o_MEM_DATA,
    input  logic              i_MEM_ACK,
    output logic [7:0]        o_DIPSW1,
    output logic [7:0]        o_DIPSW2,
    output logic [7:0]        o_DIPSW3,
    output logic              o_ROM_DONE
);

    localparam logic [1:0] S_IDLE  = 2'd0;   // no byte held
    localparam logic [1:0] S_HALF  = 2'd1;   // even byte held
    localparam logic [1:0] S_WRITE = 2'd2;   // word write outstanding
    localparam logic [1:0] S_FLUSH = 2'd3;   // write of a half word left at end of download

    logic [1:0]        r_state;
    logic              r_wr_prev;
    logic              r_dl_prev;
    logic [15:0]       r_index;
    logic              r_last_rom;
    logic              r_rom_done;
    logic [MEM_AW-1:0] r_addr;
    logic [15:0]       r_data;
    logic [7:0]        r_dip1;
    logic [7:0]        r_dip2;
    logic [7:0]        r_dip3;

    logic              w_dl_rise;
    logic [15:0]       w_idx;
    logic              w_evt;
    logic              w_busy;
    logic              w_rom_evt;
    logic              w_dip_evt;
    logic [MEM_AW-1:0] w_waddr;
    logic              w_same_word;

    // The index is taken straight from the port on the rising edge of
    // download so a byte arriving in that very cycle is routed correctly.
    assign w_dl_rise   = i_IOCTL_DOWNLOAD & ~r_dl_prev;
    assign w_idx       = w_dl_rise ? i_IOCTL_INDEX : r_index;
    // r_dl_prev keeps a strobe that coincides with the download fall alive.
    assign w_evt       = i_IOCTL_WR & ~r_wr_prev & (i_IOCTL_DOWNLOAD | r_dl_prev);
    assign w_busy      = (r_state == S_WRITE) || (r_state == S_FLUSH);
    assign w_rom_evt   = w_evt && (w_idx == ROM_INDEX) && !w_busy;
    assign w_dip_evt   = w_evt && (w_idx == DIP_INDEX);
    assign w_waddr     = i_IOCTL_ADDR[MEM_AW:1];
    assign w_same_word = (r_state == S_HALF) && (r_addr == w_waddr);

    // Edge detectors, window index latch and ROM completion flag
    always_ff @(posedge i_HPSIO_CLK) begin
        if (i_RST) begin
            r_wr_prev  <= 1'b0;
            r_dl_prev  <= 1'b0;
            r_index    <= 16'd0;
            r_last_rom <= 1'b0;
            r_rom_done <= 1'b0;
        end else begin
            r_wr_prev <= i_IOCTL_WR;
            r_dl_prev <= i_IOCTL_DOWNLOAD;
            if (w_dl_rise) begin
                r_index    <= i_IOCTL_INDEX;
                r_last_rom <= (i_IOCTL_INDEX == ROM_INDEX);
                if (i_IOCTL_INDEX == ROM_INDEX) begin
                    r_rom_done <= 1'b0;
                end
            end else if ((r_state == S_IDLE) && !i_IOCTL_DOWNLOAD && r_last_rom && !w_rom_evt) begin
                r_rom_done <= 1'b1;
            end
        end
    end

    // Word packing FSM; address and data only change outside a request
    always_ff @(posedge i_HPSIO_CLK) begin
        if (i_RST) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE, S_HALF: begin
                    if (w_rom_evt) begin
                        r_addr <= w_waddr;
                        if (!i_IOCTL_ADDR[0]) begin
                            // low byte pre-zeroed so a flush needs no data update
                            r_data  <= {i_IOCTL_DATA, 8'h00};
                            r_state <= S_HALF;
                        end else begin
                            r_data[7:0] <= i_IOCTL_DATA;
                            if (!w_same_word) begin
                                r_data[15:8] <= 8'h00;
                            end
                            r_state <= S_WRITE;
                        end
                    end else if ((r_state == S_HALF) && !i_IOCTL_DOWNLOAD) begin
                        r_state <= S_FLUSH;
                    end
                end
                default: begin
                    if (i_MEM_ACK) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // DIP-switch byte capture; addresses beyond 2 are dropped
    always_ff @(posedge i_HPSIO_CLK) begin
        if (i_RST) begin
            r_dip1 <= 8'hFF;
            r_dip2 <= 8'hFF;
            r_dip3 <= 8'hFF;
        end else if (w_dip_evt) begin
            if (i_IOCTL_ADDR == 27'd0) r_dip1 <= i_IOCTL_DATA;
            if (i_IOCTL_ADDR == 27'd1) r_dip2 <= i_IOCTL_DATA;
            if (i_IOCTL_ADDR == 27'd2) r_dip3 <= i_IOCTL_DATA;
        end
    end

    assign o_MEM_REQ    = w_busy;
    assign o_IOCTL_WAIT = w_busy;
    assign o_MEM_ADDR   = r_addr;
    assign o_MEM_DATA   = r_data;
    assign o_DIPSW1     = r_dip1;
    assign o_DIPSW2     = r_dip2;
    assign o_DIPSW3     = r_dip3;
    assign o_ROM_DONE   = r_rom_done;

endmodule
